// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the regfile_scoreboard block.
// The master side drives indices, write data, issue and clear requests.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] RUrs1;
    logic [XLEN-1:0] RUrs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] Datawr;
    logic            RUWr;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            stall;
    logic            clr_req;
    logic            clr_busy;

    modport master (
        output rs1, rs2, rd, Datawr, RUWr, issue_valid, issue_rd, clr_req,
        input  RUrs1, RUrs2, busy_rs1, busy_rs2, stall, clr_busy
    );

    modport slave (
        input  rs1, rs2, rd, Datawr, RUWr, issue_valid, issue_rd, clr_req,
        output RUrs1, RUrs2, busy_rs1, busy_rs2, stall, clr_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with busy scoreboard and multi-cycle clear sweep.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic               CLK,
    input  logic               RSTn,
    regfile_scoreboard_if.slave bus
);
    localparam int NREG = 2 ** AW;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state;
    logic [AW-1:0]   sweep_idx;
    logic            clr_busy_q;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic            wr_en;
    logic            iss_en;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            busy1;
    logic            busy2;

    assign wr_en  = (state == IDLE) && bus.RUWr && (bus.rd != '0);
    assign iss_en = (state == IDLE) && bus.issue_valid && (bus.issue_rd != '0);

    // The sweep index starts at 1 and stops on the all-ones compare, so it never wraps to 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            sweep_idx  <= AW'(1);
            clr_busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state      <= CLEAR;
                        sweep_idx  <= AW'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweep_idx == '1) begin
                        state      <= IDLE;
                        sweep_idx  <= AW'(1);
                        clr_busy_q <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sweep_idx  <= AW'(1);
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array is reset because reset must zero every register at once, not only x0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[sweep_idx] <= '0;
        end else if (wr_en) begin
            regs[bus.rd] <= bus.Datawr;
        end
    end

    // NOTE: with non-blocking assignments the later one wins, which gives set priority over clear.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            busy <= '0;
        end else if (state == CLEAR) begin
            busy[sweep_idx] <= 1'b0;
        end else begin
            if (wr_en)  busy[bus.rd]       <= 1'b0;
            if (iss_en) busy[bus.issue_rd] <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        busy1  = busy[bus.rs1];
        busy2  = busy[bus.rs2];
        if (state == IDLE) begin
            if (bus.rs1 != '0) rdata1 = regs[bus.rs1];
            if (bus.rs2 != '0) rdata2 = regs[bus.rs2];
`ifdef RF_WRITE_BYPASS_EN
            if (wr_en && (bus.rd == bus.rs1)) begin
                rdata1 = bus.Datawr;
                busy1  = iss_en && (bus.issue_rd == bus.rs1);
            end
            if (wr_en && (bus.rd == bus.rs2)) begin
                rdata2 = bus.Datawr;
                busy2  = iss_en && (bus.issue_rd == bus.rs2);
            end
`endif
        end
    end

    assign bus.RUrs1    = rdata1;
    assign bus.RUrs2    = rdata2;
    assign bus.busy_rs1 = busy1;
    assign bus.busy_rs2 = busy2;
    assign bus.clr_busy = clr_busy_q;
    assign bus.stall    = busy1 | busy2 | clr_busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations honour RF_WRITE_BYPASS_EN.
module tb_regfile_scoreboard;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic CLK;
    logic RSTn;
    int   n_total;
    int   n_pass;
    int   sweep_cycles;

    regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .AW(AW)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_total = n_total + 1;
        assert (observed === expected) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_total         = 0;
        n_pass          = 0;
        RSTn            = 1'b0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.rd          = '0;
        bus.Datawr      = '0;
        bus.RUWr        = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.clr_req     = 1'b0;

        // Reset state
        #12;
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd7;
        #1;
        check("rst_rurs1", bus.RUrs1, 0);
        check("rst_rurs2", bus.RUrs2, 0);
        check("rst_busy_rs1", bus.busy_rs1, 0);
        check("rst_busy_rs2", bus.busy_rs2, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_clr_busy", bus.clr_busy, 0);
        RSTn = 1'b1;
        tick();

        // Basic write then read, then idle cycle keeps the value
        bus.RUWr   = 1'b1;
        bus.rd     = 5'd5;
        bus.Datawr = 32'hDEADBEEF;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("wr5_same_cycle", bus.RUrs1, 32'hDEADBEEF);
`else
        check("wr5_same_cycle", bus.RUrs1, 0);
`endif
        tick();
        bus.RUWr   = 1'b0;
        bus.Datawr = '0;
        #1;
        check("rd5_after_write", bus.RUrs1, 32'hDEADBEEF);
        tick();
        check("rd5_after_nowrite", bus.RUrs1, 32'hDEADBEEF);

        // x0 write discarded, x0 never busy
        bus.RUWr   = 1'b1;
        bus.rd     = 5'd0;
        bus.Datawr = 32'h1234;
        bus.rs1    = 5'd0;
        tick();
        bus.RUWr = 1'b0;
        #1;
        check("x0_read", bus.RUrs1, 0);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("x0_busy", bus.busy_rs1, 0);
        check("x0_stall", bus.stall, 0);

        // Scoreboard: issue 7, set-wins on simultaneous writeback, lone writeback clears
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs2         = 5'd7;
        #1;
        check("busy7_after_issue", bus.busy_rs2, 1);
        check("stall_busy7", bus.stall, 1);
        bus.RUWr        = 1'b1;
        bus.rd          = 5'd7;
        bus.Datawr      = 32'h77;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        #1;
        check("busy7_wb_and_issue_same_cycle", bus.busy_rs2, 1);
        tick();
        bus.RUWr        = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        check("busy7_set_wins", bus.busy_rs2, 1);
        check("rd7_data", bus.RUrs2, 32'h77);
        bus.RUWr   = 1'b1;
        bus.Datawr = 32'h700;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("busy7_lone_wb_same_cycle", bus.busy_rs2, 0);
`else
        check("busy7_lone_wb_same_cycle", bus.busy_rs2, 1);
`endif
        tick();
        bus.RUWr = 1'b0;
        #1;
        check("busy7_cleared", bus.busy_rs2, 0);
        check("stall_cleared", bus.stall, 0);
        check("rd7_data2", bus.RUrs2, 32'h700);

        // Fill regs 1..31 with their index, mark 12 busy
        for (int i = 1; i < 32; i++) begin
            bus.RUWr   = 1'b1;
            bus.rd     = AW'(i);
            bus.Datawr = XLEN'(i);
            tick();
        end
        bus.RUWr        = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1         = 5'd31;
        bus.rs2         = 5'd12;
        #1;
        check("fill_rd31", bus.RUrs1, 31);
        check("fill_rd12", bus.RUrs2, 12);
        check("fill_busy12", bus.busy_rs2, 1);

        // Clear sweep: 31 cycles, writes/issues/clr_req ignored
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req     = 1'b0;
        bus.RUWr        = 1'b1;
        bus.rd          = 5'd3;
        bus.Datawr      = 32'hFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        #1;
        check("sweep_clr_busy", bus.clr_busy, 1);
        check("sweep_read_forced0", bus.RUrs1, 0);
        check("sweep_stall", bus.stall, 1);
        sweep_cycles = 0;
        while (bus.clr_busy && sweep_cycles < 40) begin
            sweep_cycles = sweep_cycles + 1;
            bus.clr_req  = (sweep_cycles == 5);
            tick();
        end
        bus.RUWr        = 1'b0;
        bus.issue_valid = 1'b0;
        bus.clr_req     = 1'b0;
        check("sweep_length", sweep_cycles, 31);
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = AW'(i);
            bus.rs2 = AW'(i);
            #1;
            check($sformatf("post_clear_rd%0d", i), bus.RUrs1, 0);
            check($sformatf("post_clear_busy%0d", i), bus.busy_rs2, 0);
        end
        tick();
        check("no_restart", bus.clr_busy, 0);

        // Reset in the middle of a sweep
        bus.RUWr   = 1'b1;
        bus.rd     = 5'd30;
        bus.Datawr = 32'h30;
        tick();
        bus.RUWr        = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd29;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1         = 5'd30;
        bus.rs2         = 5'd29;
        #1;
        check("pre_rst_rd30", bus.RUrs1, 32'h30);
        check("pre_rst_busy29", bus.busy_rs2, 1);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_sweep_clr_busy", bus.clr_busy, 1);
        RSTn = 1'b0;
        #1;
        check("rst_mid_clr_busy", bus.clr_busy, 0);
        check("rst_mid_rd30", bus.RUrs1, 0);
        check("rst_mid_busy29", bus.busy_rs2, 0);
        check("rst_mid_stall", bus.stall, 0);
        #2;
        RSTn = 1'b1;
        tick();
        check("rst_mid_not_resumed", bus.clr_busy, 0);
        bus.RUWr   = 1'b1;
        bus.rd     = 5'd3;
        bus.Datawr = 32'hC0FFEE;
        bus.rs1    = 5'd3;
        tick();
        bus.RUWr = 1'b0;
        #1;
        check("post_rst_write3", bus.RUrs1, 32'hC0FFEE);

        // Write bypass vs. registered read
        bus.RUWr   = 1'b1;
        bus.rd     = 5'd9;
        bus.Datawr = 32'h11;
        tick();
        bus.RUWr        = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1         = 5'd9;
        bus.RUWr        = 1'b1;
        bus.Datawr      = 32'hA5A5A5A5;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("bypass_rd9", bus.RUrs1, 32'hA5A5A5A5);
        check("bypass_busy9", bus.busy_rs1, 0);
`else
        check("bypass_rd9", bus.RUrs1, 32'h11);
        check("bypass_busy9", bus.busy_rs1, 1);
`endif
        tick();
        bus.RUWr = 1'b0;
        #1;
        check("after_edge_rd9", bus.RUrs1, 32'hA5A5A5A5);
        check("after_edge_busy9", bus.busy_rs1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
